// File: rtl/vec_issue_sched.sv
// vec_issue_sched: in-order issue scheduler for the 16-lane vector datapath.
// Decoded instructions are buffered in a small FIFO. The head issues to the LSU
// (load/store) or the ALU (add/mul, dot) once that unit is idle and the vector
// register scoreboard shows no pending writer on any register it touches.
// Each unit then runs a latency wait followed by two 16-element beats.
// Optional feature: define VSCHED_PERF_CNT_EN to add the stall_cnt/issue_cnt
// saturating performance counters.
module vec_issue_sched #(
  parameter int QDEPTH  = 4,
  parameter int NVREG   = 4,
  parameter int LSU_LAT = 4,
  parameter int ALU_LAT = 1,
  localparam int VRW = $clog2(NVREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_op,
  input  logic [VRW-1:0] in_vd,
  input  logic [VRW-1:0] in_vs1,
  input  logic [VRW-1:0] in_vs2,
  input  logic [1:0]     in_sreg,
  output logic           lsu_beat_v,
  output logic           lsu_beat,
  output logic           lsu_store,
  output logic [VRW-1:0] lsu_vreg,
  output logic [1:0]     lsu_sreg,
  output logic           alu_beat_v,
  output logic           alu_beat,
  output logic           alu_dot,
  output logic [VRW-1:0] alu_vd,
  output logic [VRW-1:0] alu_vs1,
  output logic [VRW-1:0] alu_vs2,
  output logic           retire,
  output logic [1:0]     retire_n,
  output logic           busy
`ifdef VSCHED_PERF_CNT_EN
  ,
  output logic [15:0]    stall_cnt,
  output logic [15:0]    issue_cnt
`endif
);

  localparam int QW     = $clog2(QDEPTH);
  localparam int MAXLAT = (LSU_LAT > ALU_LAT) ? LSU_LAT : ALU_LAT;
  localparam int CW     = (MAXLAT > 0) ? $clog2(MAXLAT + 1) : 1;
  localparam logic [CW-1:0] LSU_WAIT_INIT = (LSU_LAT > 0) ? CW'(LSU_LAT - 1) : '0;
  localparam logic [CW-1:0] ALU_WAIT_INIT = (ALU_LAT > 0) ? CW'(ALU_LAT - 1) : '0;

  typedef enum logic [1:0] {FU_IDLE, FU_WAIT, FU_BEAT0, FU_BEAT1} fu_state_e;

  logic [1:0]     q_op   [QDEPTH];
  logic [VRW-1:0] q_vd   [QDEPTH];
  logic [VRW-1:0] q_vs1  [QDEPTH];
  logic [VRW-1:0] q_vs2  [QDEPTH];
  logic [1:0]     q_sreg [QDEPTH];
  logic [QW-1:0]  wr_ptr, rd_ptr;
  logic [QW:0]    count;

  fu_state_e      lsu_state, alu_state;
  logic [CW-1:0]  lsu_cnt, alu_cnt;
  logic [NVREG-1:0] sb, sb_set, sb_clr;

  logic           enq, head_valid, head_lsu, head_writes, unit_free, hazard, issue;
  logic [1:0]     head_op, head_sreg;
  logic [VRW-1:0] head_vd, head_vs1, head_vs2;
  logic           lsu_b1, alu_b1;

  assign in_ready   = (count != (QW+1)'(QDEPTH));
  assign enq        = in_valid & in_ready;
  assign head_valid = (count != '0);
  assign head_op    = q_op[rd_ptr];
  assign head_vd    = q_vd[rd_ptr];
  assign head_vs1   = q_vs1[rd_ptr];
  assign head_vs2   = q_vs2[rd_ptr];
  assign head_sreg  = q_sreg[rd_ptr];
  assign head_lsu   = ~head_op[1];
  assign head_writes = (head_op != 2'b01);
  assign unit_free  = head_lsu ? (lsu_state == FU_IDLE) : (alu_state == FU_IDLE);
  // vd is checked for every op: WAW for writers, RAW for store data and dot accumulator
  assign hazard     = sb[head_vd] | (~head_lsu & (sb[head_vs1] | sb[head_vs2]));
  assign issue      = head_valid & unit_free & ~hazard;

  // FIFO pointers and occupancy; an issue frees the head slot at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + QW'(1);
      if (issue) rd_ptr <= rd_ptr + QW'(1);
      count <= count + (QW+1)'(enq) - (QW+1)'(issue);
    end
  end

  // FIFO payload storage, written only on an accepted enqueue
  always_ff @(posedge clk) begin
    if (enq) begin
      q_op[wr_ptr]   <= in_op;
      q_vd[wr_ptr]   <= in_vd;
      q_vs1[wr_ptr]  <= in_vs1;
      q_vs2[wr_ptr]  <= in_vs2;
      q_sreg[wr_ptr] <= in_sreg;
    end
  end

  // Scoreboard set/clear vectors: writers mark vd at issue, release it when BEAT1 ends
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (lsu_state == FU_BEAT1 && !lsu_store) sb_clr[lsu_vreg] = 1'b1;
    if (alu_state == FU_BEAT1)               sb_clr[alu_vd]   = 1'b1;
    if (issue && head_writes)                sb_set[head_vd]  = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else     sb <= (sb & ~sb_clr) | sb_set;
  end

  // LSU sequencer: latency wait then two beats; operands held until back in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_state <= FU_IDLE;
      lsu_cnt   <= '0;
      lsu_store <= 1'b0;
      lsu_vreg  <= '0;
      lsu_sreg  <= '0;
    end else begin
      case (lsu_state)
        FU_IDLE: if (issue && head_lsu) begin
          lsu_state <= (LSU_LAT == 0) ? FU_BEAT0 : FU_WAIT;
          lsu_cnt   <= LSU_WAIT_INIT;
          lsu_store <= head_op[0];
          lsu_vreg  <= head_vd;
          lsu_sreg  <= head_sreg;
        end
        FU_WAIT: begin
          if (lsu_cnt == '0) lsu_state <= FU_BEAT0;
          else               lsu_cnt   <= lsu_cnt - CW'(1);
        end
        FU_BEAT0: lsu_state <= FU_BEAT1;
        FU_BEAT1: begin
          lsu_state <= FU_IDLE;
          lsu_store <= 1'b0;
          lsu_vreg  <= '0;
          lsu_sreg  <= '0;
        end
        default: lsu_state <= FU_IDLE;
      endcase
    end
  end

  // ALU sequencer: same shape as the LSU with its own latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_state <= FU_IDLE;
      alu_cnt   <= '0;
      alu_dot   <= 1'b0;
      alu_vd    <= '0;
      alu_vs1   <= '0;
      alu_vs2   <= '0;
    end else begin
      case (alu_state)
        FU_IDLE: if (issue && !head_lsu) begin
          alu_state <= (ALU_LAT == 0) ? FU_BEAT0 : FU_WAIT;
          alu_cnt   <= ALU_WAIT_INIT;
          alu_dot   <= head_op[0];
          alu_vd    <= head_vd;
          alu_vs1   <= head_vs1;
          alu_vs2   <= head_vs2;
        end
        FU_WAIT: begin
          if (alu_cnt == '0) alu_state <= FU_BEAT0;
          else               alu_cnt   <= alu_cnt - CW'(1);
        end
        FU_BEAT0: alu_state <= FU_BEAT1;
        FU_BEAT1: begin
          alu_state <= FU_IDLE;
          alu_dot   <= 1'b0;
          alu_vd    <= '0;
          alu_vs1   <= '0;
          alu_vs2   <= '0;
        end
        default: alu_state <= FU_IDLE;
      endcase
    end
  end

  assign lsu_b1     = (lsu_state == FU_BEAT1);
  assign alu_b1     = (alu_state == FU_BEAT1);
  assign lsu_beat_v = (lsu_state == FU_BEAT0) | lsu_b1;
  assign lsu_beat   = lsu_b1;
  assign alu_beat_v = (alu_state == FU_BEAT0) | alu_b1;
  assign alu_beat   = alu_b1;
  assign retire     = lsu_b1 | alu_b1;
  assign retire_n   = {1'b0, lsu_b1} + {1'b0, alu_b1};
  assign busy       = head_valid | (lsu_state != FU_IDLE) | (alu_state != FU_IDLE);

`ifdef VSCHED_PERF_CNT_EN
  // Saturating counters of head stall cycles and issued instructions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (head_valid && !issue && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (issue && issue_cnt != 16'hFFFF)                issue_cnt <= issue_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_issue_sched.sv
// Testbench for vec_issue_sched. A timing model computes, for every accepted
// instruction, its issue cycle from queue order, unit availability and the
// completion cycle of the last writer of each register it touches. Expected
// beats go into per-unit queues that a negedge monitor pops and compares.
module tb_vec_issue_sched;

  localparam int QDEPTH  = 4;
  localparam int LSU_LAT = 4;
  localparam int ALU_LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = '0, in_vd = '0, in_vs1 = '0, in_vs2 = '0, in_sreg = '0;
  logic       lsu_beat_v, lsu_beat, lsu_store;
  logic [1:0] lsu_vreg, lsu_sreg;
  logic       alu_beat_v, alu_beat, alu_dot;
  logic [1:0] alu_vd, alu_vs1, alu_vs2;
  logic       retire, busy;
  logic [1:0] retire_n;

  always #5 clk = ~clk;

  vec_issue_sched #(.QDEPTH(QDEPTH), .NVREG(4), .LSU_LAT(LSU_LAT), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_sreg(in_sreg),
    .lsu_beat_v(lsu_beat_v), .lsu_beat(lsu_beat), .lsu_store(lsu_store),
    .lsu_vreg(lsu_vreg), .lsu_sreg(lsu_sreg),
    .alu_beat_v(alu_beat_v), .alu_beat(alu_beat), .alu_dot(alu_dot),
    .alu_vd(alu_vd), .alu_vs1(alu_vs1), .alu_vs2(alu_vs2),
    .retire(retire), .retire_n(retire_n), .busy(busy)
  );

  typedef struct { int enq; int iss; int b1; bit lsu; } inst_t;
  typedef struct { int cyc; bit beat; bit flag; logic [1:0] vd, vs1, vs2, sreg; } beat_t;

  inst_t recs[$];
  beat_t lsu_exp[$];
  beat_t alu_exp[$];
  int    last_iss, lsu_free, alu_free;
  int    reg_ready[4];
  int    cyc, errors, checks, phase, t5_base;
  bit    mon_en;

  // Count one comparison and report it when it does not hold
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Forget every outstanding instruction, as a reset does
  function automatic void modelReset();
    recs.delete();
    lsu_exp.delete();
    alu_exp.delete();
    last_iss = -100;
    lsu_free = -100;
    alu_free = -100;
    for (int r = 0; r < 4; r++) reg_ready[r] = -100;
  endfunction

  // Work out when an instruction accepted at cycle e issues and beats
  function automatic void modelEnqueue(input int e, input logic [1:0] op, vd, vs1, vs2, sreg);
    bit    lsu;
    int    t, lat;
    inst_t r;
    beat_t b;
    lsu = !op[1];
    lat = lsu ? LSU_LAT : ALU_LAT;
    t = imax(e + 1, last_iss + 1);
    t = imax(t, lsu ? lsu_free : alu_free);
    t = imax(t, reg_ready[vd]);
    if (!lsu) t = imax(t, imax(reg_ready[vs1], reg_ready[vs2]));
    r.enq = e; r.iss = t; r.b1 = t + lat + 2; r.lsu = lsu;
    recs.push_back(r);
    last_iss = t;
    if (lsu) lsu_free = r.b1 + 1; else alu_free = r.b1 + 1;
    if (op != 2'b01) reg_ready[vd] = r.b1 + 1;
    for (int k = 0; k < 2; k++) begin
      b.cyc  = t + lat + 1 + k;
      b.beat = (k == 1);
      b.flag = op[0];
      b.vd   = vd;
      b.vs1  = lsu ? 2'd0 : vs1;
      b.vs2  = lsu ? 2'd0 : vs2;
      b.sreg = lsu ? sreg : 2'd0;
      if (lsu) lsu_exp.push_back(b); else alu_exp.push_back(b);
    end
  endfunction

  function automatic bit modelReady(input int c);
    int occ = 0;
    foreach (recs[i]) if (recs[i].enq < c && recs[i].iss >= c) occ++;
    return occ < QDEPTH;
  endfunction

  function automatic bit modelBusy(input int c);
    foreach (recs[i]) if (recs[i].enq < c && c <= recs[i].b1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit modelActive(input int c, input bit lsu);
    foreach (recs[i]) if (recs[i].lsu == lsu && recs[i].iss < c && c <= recs[i].b1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int modelRetire(input int c);
    int n = 0;
    foreach (recs[i]) if (recs[i].b1 == c) n++;
    return n;
  endfunction

  function automatic int modelMaxB1();
    int m = -100;
    foreach (recs[i]) m = imax(m, recs[i].b1);
    return m;
  endfunction

  // Drive one cycle of input, check in_ready against the model, advance to next cycle
  task automatic applyStimulus(input bit offer, input logic [1:0] op, vd, vs1, vs2, sreg,
                               output bit accepted);
    bit exp_ready;
    in_valid = offer;
    in_op = op; in_vd = vd; in_vs1 = vs1; in_vs2 = vs2; in_sreg = sreg;
    exp_ready = modelReady(cyc);
    #1;
    checkOutput("in_ready", int'(in_ready), int'(exp_ready));
    accepted = offer && exp_ready;
    if (accepted) modelEnqueue(cyc, op, vd, vs1, vs2, sreg);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleCycle();
    bit acc;
    applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, acc);
  endtask

  // Wait gap idle cycles, then offer one instruction until the queue takes it
  task automatic sendInstr(input int gap, input logic [1:0] op, vd, vs1, vs2, sreg);
    bit acc = 1'b0;
    int tries = 0;
    repeat (gap) idleCycle();
    while (!acc && tries < 64) begin
      applyStimulus(1'b1, op, vd, vs1, vs2, sreg, acc);
      tries++;
    end
    if (!acc) checkOutput("enqueue_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (cyc <= modelMaxB1() + 1 && guard < 500) begin
      idleCycle();
      guard++;
    end
    if (guard >= 500) checkOutput("drain_timeout", 0, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_retire"}, int'({retire, retire_n}), 0);
    checkOutput({tag, "_lsu_out"}, int'({lsu_beat_v, lsu_beat, lsu_store, lsu_vreg, lsu_sreg}), 0);
    checkOutput({tag, "_alu_out"}, int'({alu_beat_v, alu_beat, alu_dot, alu_vd, alu_vs1, alu_vs2}), 0);
  endtask

  // Monitor: pop and compare expected beats, plus per-cycle retire/busy/idle checks
  always @(negedge clk) begin
    beat_t b;
    int    n;
    if (mon_en) begin
      if (lsu_beat_v) begin
        if (lsu_exp.size() == 0) checkOutput("lsu_unexpected_beat", 1, 0);
        else begin
          b = lsu_exp.pop_front();
          checkOutput("lsu_beat_cycle", cyc, b.cyc);
          checkOutput("lsu_beat", int'(lsu_beat), int'(b.beat));
          checkOutput("lsu_store", int'(lsu_store), int'(b.flag));
          checkOutput("lsu_vreg", int'(lsu_vreg), int'(b.vd));
          checkOutput("lsu_sreg", int'(lsu_sreg), int'(b.sreg));
        end
      end else if (lsu_exp.size() != 0 && lsu_exp[0].cyc <= cyc) begin
        void'(lsu_exp.pop_front());
        checkOutput("lsu_beat_missing", 0, 1);
      end
      if (alu_beat_v) begin
        if (alu_exp.size() == 0) checkOutput("alu_unexpected_beat", 1, 0);
        else begin
          b = alu_exp.pop_front();
          checkOutput("alu_beat_cycle", cyc, b.cyc);
          checkOutput("alu_beat", int'(alu_beat), int'(b.beat));
          checkOutput("alu_dot", int'(alu_dot), int'(b.flag));
          checkOutput("alu_vd", int'(alu_vd), int'(b.vd));
          checkOutput("alu_vs1", int'(alu_vs1), int'(b.vs1));
          checkOutput("alu_vs2", int'(alu_vs2), int'(b.vs2));
        end
      end else if (alu_exp.size() != 0 && alu_exp[0].cyc <= cyc) begin
        void'(alu_exp.pop_front());
        checkOutput("alu_beat_missing", 0, 1);
      end
      n = modelRetire(cyc);
      checkOutput("retire_n", int'(retire_n), n);
      checkOutput("retire", int'(retire), int'(n != 0));
      checkOutput("busy", int'(busy), int'(modelBusy(cyc)));
      if (!modelActive(cyc, 1'b1))
        checkOutput("lsu_idle_outputs", int'({lsu_beat_v, lsu_store, lsu_vreg, lsu_sreg}), 0);
      if (!modelActive(cyc, 1'b0))
        checkOutput("alu_idle_outputs", int'({alu_beat_v, alu_dot, alu_vd, alu_vs1, alu_vs2}), 0);
      if (phase == 1) begin
        if (cyc == 6 || cyc == 7 || cyc == 13 || cyc == 14)
          checkOutput("t12_lsu_beat_v", int'(lsu_beat_v), 1);
        if (cyc == 17 || cyc == 18) checkOutput("t3_alu_beat_v", int'(alu_beat_v), 1);
        if (cyc == 7) checkOutput("t1_retire", int'(retire), 1);
        if (cyc == 5) checkOutput("t4_in_ready_full", int'(in_ready), 0);
      end
      if (phase == 2 && cyc == t5_base + 7) checkOutput("t5_retire_n", int'(retire_n), 2);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed scenarios, random traffic, mid-flight reset
  initial begin
    errors = 0; checks = 0; cyc = 0; phase = 0; t5_base = 0; mon_en = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    phase = 1;
    sendInstr(0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd1);
    sendInstr(0, 2'b00, 2'd1, 2'd0, 2'd0, 2'd2);
    sendInstr(0, 2'b10, 2'd2, 2'd0, 2'd1, 2'd0);
    sendInstr(0, 2'b11, 2'd3, 2'd2, 2'd0, 2'd0);
    sendInstr(0, 2'b01, 2'd2, 2'd0, 2'd0, 2'd3);
    sendInstr(0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
    drain();

    phase = 2;
    t5_base = cyc;
    sendInstr(0, 2'b00, 2'd0, 2'd0, 2'd0, 2'd1);
    sendInstr(2, 2'b10, 2'd1, 2'd2, 2'd3, 2'd0);
    sendInstr(0, 2'b11, 2'd0, 2'd0, 2'd1, 2'd0);
    drain();

    phase = 3;
    for (int i = 0; i < 250; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      sendInstr(gap, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    drain();

    phase = 4;
    for (int i = 0; i < 4; i++) sendInstr(0, 2'b00, 2'(i), 2'd0, 2'd0, 2'(i));
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checkResetState("t6_async");
    @(posedge clk);
    #1;
    cyc++;
    checkResetState("t6_next");
    rst = 1'b0;
    modelReset();
    mon_en = 1'b1;
    repeat (12) idleCycle();

    phase = 5;
    for (int i = 0; i < 20; i++)
      sendInstr(0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    drain();

    checkOutput("lsu_expected_left", lsu_exp.size(), 0);
    checkOutput("alu_expected_left", alu_exp.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
